// File: rtl/imem_loadable.sv
// Instruction memory for the IF stage: registered 1-cycle fetch with stall, plus a
// byte-serial run-time loader. Optional `IMEM_CHECKSUM_EN adds an XOR checksum of loaded words.
module imem_loadable #(
  parameter int unsigned ADDR_W = 31,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] addr,
  input  logic              stall,
  output logic [31:0]       data,
  output logic              data_valid,
  output logic              addr_fault,
  input  logic              ld_start,
  input  logic              ld_byte_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_busy,
  output logic              ld_done,
`ifdef IMEM_CHECKSUM_EN
  output logic [31:0]       ld_checksum,
`endif
  output logic [CNT_W-1:0]  ld_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [CNT_W-1:0]   ld_count_q, ld_count_d;
  logic [31:0]        asm_q, asm_d;
  logic [31:0]        data_q, data_d;
  logic               dv_q, dv_d;
  logic               af_q, af_d;
  logic [31:0]        ck_q, ck_d;

  logic [31:0]        asm_shift;
  logic               mem_we;
  logic [ADDR_W-3:0]  fetch_idx;
  logic               fetch_ok;

  // Not reset: contents survive a reset and start out as NOPs.
  logic [31:0]        mem_q [DEPTH] = '{default: '0};

  assign fetch_idx = addr[ADDR_W-1:2];
  assign fetch_ok  = (fetch_idx < (ADDR_W-2)'(DEPTH)) && (addr[1:0] == 2'b00);
  assign asm_shift = {asm_q[23:0], ld_byte};

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    ld_count_d = ld_count_q;
    asm_d      = asm_q;
    data_d     = data_q;
    dv_d       = dv_q;
    af_d       = af_q;
    ck_d       = ck_q;
    mem_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ld_start) begin
          state_d    = LOAD;
          wr_ptr_d   = '0;
          byte_cnt_d = '0;
          ld_count_d = '0;
          ck_d       = '0;
          dv_d       = 1'b0;
          af_d       = 1'b0;
        end else if (!stall) begin
          if (fetch_req) begin
            data_d = fetch_ok ? mem_q[fetch_idx[AW-1:0]] : '0;
            dv_d   = 1'b1;
            af_d   = !fetch_ok;
          end else begin
            dv_d = 1'b0;
            af_d = 1'b0;
          end
        end
      end
      LOAD: begin
        dv_d = 1'b0;
        af_d = 1'b0;
        // Abort takes priority over a byte arriving in the same cycle.
        if (ld_start) begin
          state_d = DONE;
        end else if (ld_byte_valid) begin
          asm_d      = asm_shift;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            mem_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + AW'(1);
            ld_count_d = ld_count_q + CNT_W'(1);
            ck_d       = ck_q ^ asm_shift;
            if (wr_ptr_q == AW'(DEPTH - 1)) state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        dv_d    = 1'b0;
        af_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      ld_count_q <= '0;
      asm_q      <= '0;
      data_q     <= '0;
      dv_q       <= 1'b0;
      af_q       <= 1'b0;
      ck_q       <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      ld_count_q <= ld_count_d;
      asm_q      <= asm_d;
      data_q     <= data_d;
      dv_q       <= dv_d;
      af_q       <= af_d;
      ck_q       <= ck_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= asm_shift;
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign addr_fault = af_q;
  assign ld_busy    = (state_q == LOAD);
  assign ld_done    = (state_q == DONE);
  assign ld_count   = ld_count_q;
`ifdef IMEM_CHECKSUM_EN
  assign ld_checksum = ck_q;
`else
  logic unused_ck;
  assign unused_ck = ^ck_q;
`endif

endmodule

// File: tb/tb_imem_loadable.sv
// Directed bench for imem_loadable: table-driven fetch vectors plus loader,
// abort, auto-finish, stall and mid-load reset sequences.
module tb_imem_loadable;

  localparam int unsigned ADDR_W = 31;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              fetch_req;
  logic [ADDR_W-1:0] addr;
  logic              stall;
  logic [31:0]       data;
  logic              data_valid;
  logic              addr_fault;
  logic              ld_start;
  logic              ld_byte_valid;
  logic [7:0]        ld_byte;
  logic              ld_busy;
  logic              ld_done;
  logic [CNT_W-1:0]  ld_count;
`ifdef IMEM_CHECKSUM_EN
  logic [31:0]       ld_checksum;
`endif

  int checks = 0;
  int errors = 0;

  imem_loadable #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .addr(addr), .stall(stall),
    .data(data), .data_valid(data_valid), .addr_fault(addr_fault),
    .ld_start(ld_start), .ld_byte_valid(ld_byte_valid), .ld_byte(ld_byte),
    .ld_busy(ld_busy), .ld_done(ld_done),
`ifdef IMEM_CHECKSUM_EN
    .ld_checksum(ld_checksum),
`endif
    .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic [30:0] a;
    logic [31:0] exp_data;
    logic        exp_valid;
    logic        exp_fault;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fetch_chk(input string name, input logic [30:0] a, input logic [31:0] exp_d,
                           input logic exp_f);
    fetch_req = 1'b1; addr = a;
    step();
    fetch_req = 1'b0;
    chk({name, ".data"}, data, exp_d);
    chk({name, ".valid"}, {31'b0, data_valid}, 32'd1);
    chk({name, ".fault"}, {31'b0, addr_fault}, {31'b0, exp_f});
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_byte_valid = 1'b1; ld_byte = b;
    step();
    ld_byte_valid = 1'b0;
  endtask

  function automatic logic [7:0] sb(input int i);
    return 8'(i * 7 + 3);
  endfunction

  function automatic logic [31:0] sw(input int w);
    return {sb(4*w), sb(4*w+1), sb(4*w+2), sb(4*w+3)};
  endfunction

  vec_t vt[9];
  logic [7:0] load1[8];
  logic [31:0] xsum;

  initial begin
    load1 = '{8'h3c, 8'h11, 8'h40, 8'h00, 8'h26, 8'h31, 8'h00, 8'h04};
    vt[0] = '{1'b1, 31'd0,    32'h3c114000, 1'b1, 1'b0};
    vt[1] = '{1'b1, 31'd4,    32'h26310004, 1'b1, 1'b0};
    vt[2] = '{1'b1, 31'd1024, 32'h0,        1'b1, 1'b1};
    vt[3] = '{1'b1, 31'd6,    32'h0,        1'b1, 1'b1};
    vt[4] = '{1'b1, 31'd4,    32'h26310004, 1'b1, 1'b0};
    vt[5] = '{1'b0, 31'd0,    32'h26310004, 1'b0, 1'b0};
    vt[6] = '{1'b1, 31'd1020, 32'h0,        1'b1, 1'b0};
    vt[7] = '{1'b1, 31'd3,    32'h0,        1'b1, 1'b1};
    vt[8] = '{1'b1, 31'h7fff_fffc, 32'h0,   1'b1, 1'b1};

    reset = 1'b0; fetch_req = 1'b0; addr = '0; stall = 1'b0;
    ld_start = 1'b0; ld_byte_valid = 1'b0; ld_byte = '0;
    step(); step();
    chk("rst.data", data, 32'h0);
    chk("rst.valid", {31'b0, data_valid}, 32'd0);
    chk("rst.fault", {31'b0, addr_fault}, 32'd0);
    chk("rst.busy", {31'b0, ld_busy}, 32'd0);
    chk("rst.done", {31'b0, ld_done}, 32'd0);
    chk("rst.count", 32'(ld_count), 32'd0);
    reset = 1'b1;
    step();
    fetch_chk("pwrup0", 31'd0, 32'h0, 1'b0);

    // Basic two-word load terminated by ld_start
    ld_start = 1'b1; step(); ld_start = 1'b0;
    chk("ld1.busy", {31'b0, ld_busy}, 32'd1);
    for (int i = 0; i < 8; i++) send_byte(load1[i]);
    chk("ld1.nodone", {31'b0, ld_done}, 32'd0);
    ld_start = 1'b1; step(); ld_start = 1'b0;
    chk("ld1.done", {31'b0, ld_done}, 32'd1);
    chk("ld1.count", 32'(ld_count), 32'd2);
    step();
    chk("ld1.donepulse", {31'b0, ld_done}, 32'd0);
    chk("ld1.idle", {31'b0, ld_busy}, 32'd0);
`ifdef IMEM_CHECKSUM_EN
    chk("ld1.cksum", ld_checksum, 32'h1a204004);
`endif

    for (int i = 0; i < 9; i++) begin
      fetch_req = vt[i].req; addr = vt[i].a;
      step();
      chk($sformatf("vec%0d.data", i), data, vt[i].exp_data);
      chk($sformatf("vec%0d.valid", i), {31'b0, data_valid}, {31'b0, vt[i].exp_valid});
      chk($sformatf("vec%0d.fault", i), {31'b0, addr_fault}, {31'b0, vt[i].exp_fault});
    end

    // Stall holds registered outputs while the address moves
    fetch_chk("pre_stall", 31'd4, 32'h26310004, 1'b0);
    stall = 1'b1; fetch_req = 1'b1; addr = 31'd8;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall%0d.data", i), data, 32'h26310004);
      chk($sformatf("stall%0d.valid", i), {31'b0, data_valid}, 32'd1);
      chk($sformatf("stall%0d.fault", i), {31'b0, addr_fault}, 32'd0);
    end
    stall = 1'b0;
    step();
    chk("unstall.data", data, 32'h0);
    fetch_req = 1'b0;

    // ld_start wins over a simultaneous fetch; abort discards partial word and the same-cycle byte
    fetch_req = 1'b1; addr = 31'd4; ld_start = 1'b1;
    step();
    fetch_req = 1'b0; ld_start = 1'b0;
    chk("ab.valid", {31'b0, data_valid}, 32'd0);
    chk("ab.busy", {31'b0, ld_busy}, 32'd1);
    chk("ab.count0", 32'(ld_count), 32'd0);
    send_byte(8'haa); send_byte(8'hbb); send_byte(8'hcc); send_byte(8'hdd);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    ld_start = 1'b1; ld_byte_valid = 1'b1; ld_byte = 8'h44;
    step();
    ld_start = 1'b0; ld_byte_valid = 1'b0;
    chk("ab.done", {31'b0, ld_done}, 32'd1);
    chk("ab.count", 32'(ld_count), 32'd1);
    step();
`ifdef IMEM_CHECKSUM_EN
    chk("ab.cksum", ld_checksum, 32'haabbccdd);
`endif
    fetch_chk("ab.w0", 31'd0, 32'haabbccdd, 1'b0);
    fetch_chk("ab.w1", 31'd4, 32'h26310004, 1'b0);
    step();
    chk("ab.count_hold", 32'(ld_count), 32'd1);

    // Full-memory stream auto-finishes after the last byte
    ld_start = 1'b1; step(); ld_start = 1'b0;
    xsum = '0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      send_byte(sb(i));
      if (i == 4 * DEPTH - 2) chk("full.busy_prelast", {31'b0, ld_busy}, 32'd1);
    end
    for (int w = 0; w < DEPTH; w++) xsum ^= sw(w);
    chk("full.done", {31'b0, ld_done}, 32'd1);
    chk("full.busy", {31'b0, ld_busy}, 32'd0);
    chk("full.count", 32'(ld_count), DEPTH);
    step();
    chk("full.donepulse", {31'b0, ld_done}, 32'd0);
`ifdef IMEM_CHECKSUM_EN
    chk("full.cksum", ld_checksum, xsum);
`endif
    fetch_chk("full.w0", 31'd0, sw(0), 1'b0);
    fetch_chk("full.w255", 31'd1020, sw(255), 1'b0);
    fetch_chk("full.w1", 31'd4, sw(1), 1'b0);

    // Reset after 5 bytes: word 0 written, word 1 untouched
    ld_start = 1'b1; step(); ld_start = 1'b0;
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    reset = 1'b0;
    #1;
    chk("mrst.busy", {31'b0, ld_busy}, 32'd0);
    chk("mrst.done", {31'b0, ld_done}, 32'd0);
    chk("mrst.count", 32'(ld_count), 32'd0);
    chk("mrst.valid", {31'b0, data_valid}, 32'd0);
`ifdef IMEM_CHECKSUM_EN
    chk("mrst.cksum", ld_checksum, 32'h0);
`endif
    step();
    reset = 1'b1;
    step();
    fetch_chk("mrst.w0", 31'd0, 32'h01020304, 1'b0);
    fetch_chk("mrst.w1", 31'd4, sw(1), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
Parametrised instruction memory for the MIPS pipeline's IF stage. It returns a word from a byte address with a registered 1-cycle read and a pipeline stall input. Contents are loadable at run time through a byte-serial loader port (UART bootloader path) driven by an internal FSM. Out-of-range and misaligned fetches return a NOP and raise a fault flag.

Parameters:
ADDR_W, 31, fetch byte-address width
DEPTH, 256, number of 32-bit words; must be a power of 2, at least 4
CNT_W, $clog2(DEPTH+1), width of ld_count

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
fetch_req  input  1  fetch request from IF stage
addr  input  ADDR_W  fetch byte address
stall  input  1  pipeline stall: hold registered outputs
data  output  32  fetched instruction
data_valid  output  1  data holds a fetch result
addr_fault  output  1  result came from an out-of-range or misaligned address
ld_start  input  1  pulse: start a load in IDLE; terminate a load in LOAD
ld_byte_valid  input  1  ld_byte is valid this cycle
ld_byte  input  8  load byte, MSB of word first
ld_busy  output  1  loader active (state LOAD)
ld_done  output  1  one-cycle pulse when a load ends
ld_count  output  CNT_W  words written by the current or most recent load

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE. wr_ptr, byte_cnt and ld_count go to 0. Outputs data=0, data_valid=0, addr_fault=0, ld_busy=0, ld_done=0.
- Memory array is not cleared by reset. Power-up contents are all 32'h0 (NOP). Words written before a reset are retained.
- Word index is addr[ADDR_W-1:2]. A fetch is in range iff index < DEPTH. It is misaligned iff addr[1:0] != 0.
- Fetch, IDLE only:
  - stall=1: data, data_valid and addr_fault hold their values.
  - stall=0, fetch_req=1: on the next edge, data <= (in range and aligned) ? mem[index] : 32'h0. data_valid <= 1. addr_fault <= !(in range and aligned). Latency is 1 cycle.
  - stall=0, fetch_req=0: data_valid <= 0, addr_fault <= 0, data holds.
- FSM states: IDLE, LOAD, DONE.
- IDLE -> LOAD on ld_start=1.
  - Clears wr_ptr, byte_cnt and ld_count.
  - Sets data_valid=0. ld_start beats fetch_req when both are high in the same cycle; that fetch is dropped.
- LOAD, each ld_byte_valid=1:
  - Shift byte into a 32-bit assembly register: asm <= {asm[23:0], ld_byte}. Increment byte_cnt (2 bits, wraps).
  - On the 4th byte (byte_cnt==3): write mem[wr_ptr] <= {asm[23:0], ld_byte}, then increment wr_ptr and ld_count.
  - Fetches are ignored while in LOAD. ld_busy=1, data_valid=0.
- LOAD -> DONE under either condition:
  - ld_start=1: abort. A partial word (byte_cnt != 0) is discarded. If ld_byte_valid is asserted in the same cycle, that byte is ignored.
  - The write of word DEPTH-1 completes: auto-finish.
- DONE: ld_done=1 for exactly one cycle, then -> IDLE. ld_count holds until the next ld_start or reset.
- A write and a fetch never target memory in the same cycle, because the FSM serialises them.
- Reset mid-load leaves already-written words in memory. The assembly register and partial word are lost.

Optional Feature:
Macro IMEM_CHECKSUM_EN.
- Defined: adds output port ld_checksum [31:0]. It is cleared to 0 at reset and on IDLE->LOAD. It is XORed with each word as that word is written, and holds after DONE. The bootloader uses it to verify the transfer.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset, then fetch addr=0: the cycle after the request, data=32'h00000000, data_valid=1, addr_fault=0. During reset all outputs are 0.
- Load sequence:
  - Stimulus: ld_start, then bytes 3c 11 40 00 26 31 00 04, then ld_start.
  - Load response: ld_done pulses once, ld_count=2.
  - Fetch addr=4 returns 32'h26310004 one cycle later.
  - With IMEM_CHECKSUM_EN, ld_checksum = 32'h3c114000 ^ 32'h26310004 = 32'h1a204004.
- Fetch addr=DEPTH*4 (1024): data=0, addr_fault=1, data_valid=1. Fetch addr=6: data=0, addr_fault=1.
- Fetch addr=4 with stall=1 for 3 cycles while addr changes to 8: data, data_valid and addr_fault hold for all 3 cycles.
- Abort and auto-finish:
  - Load 1 word plus 2 bytes, then ld_start: ld_count=1, and word 1 keeps its previous contents.
  - Stream 4*DEPTH bytes: auto DONE after the last byte, and ld_count=DEPTH.
- Assert reset after 5 bytes of a load: ld_busy=0, state IDLE, word 0 keeps its newly written value, word 1 is unchanged, and the next fetch works normally.
